i2s_receiver: RTL and testbench



---
 rtl/i2s_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_i2s_receiver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// -----------------------------------------------------------------------------
// i2s_receiver
//
// Deserialises the SGTL5000 I2S ADC stream (codec DOUT) into parallel
// left/right sample pairs. SCLK, LRCLK and SDIN are oversampled in the Clk
// domain, so there is only one clock in this block.
//
// Ports
//   Clk           system clock (50 MHz)
//   Reset_n       synchronous active-low reset
//   enable        low: receiver held idle, outputs frozen, lock dropped
//   SCLK          codec bit clock (asynchronous, oversampled)
//   LRCLK         codec word select, 0 = left, 1 = right (asynchronous)
//   SDIN          codec serial data, MSB first (asynchronous)
//   left_data     last complete left sample
//   right_data    last complete right sample
//   sample_valid  one-Clk pulse when left_data/right_data update as a pair
//   frame_err     one-Clk pulse when a word closes with < DATA_WIDTH bits
//   locked        high once a full left word has been framed
//
// Timing: the closing SCLK pin rise reaches sample_valid after
// SYNC_STAGES (synchroniser) + 1 (edge strobe) + 1 (output register) Clk.
// -----------------------------------------------------------------------------
module i2s_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  enable,
  input  logic                  SCLK,
  input  logic                  LRCLK,
  input  logic                  SDIN,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  sample_valid,
  output logic                  frame_err,
  output logic                  locked
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning: synchronisers, SCLK rise strobe, aligned ws/bit samples
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, lrclk_sync_q, sdin_sync_q;
  logic                   sclk_prev_q;
  logic                   rise_q;   // registered srise strobe
  logic                   ws_q;     // synced LRCLK captured with the strobe
  logic                   bit_q;    // synced SDIN captured with the strobe

  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge values of the others; = here would collapse the synchroniser.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdin_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      rise_q       <= 1'b0;
      ws_q         <= 1'b0;
      bit_q        <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], LRCLK};
      sdin_sync_q  <= {sdin_sync_q[SYNC_STAGES-2:0], SDIN};
      sclk_prev_q  <= sclk_sync_q[SYNC_STAGES-1];
      rise_q       <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      ws_q         <= lrclk_sync_q[SYNC_STAGES-1];
      bit_q        <= sdin_sync_q[SYNC_STAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  ws_prev_q, ws_prev_d;     // ws at previous strobe; also the current channel
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                  held_q, held_d;           // a left word is waiting for its right partner
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  locked_q, locked_d;

  // Word contents after this strobe's bit is appended (saturating at
  // DATA_WIDTH, so a long slot keeps only its MSBs).
  logic [DATA_WIDTH-1:0] shift_app;
  logic [CW-1:0]         count_app;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      ws_prev_q   <= 1'b0;
      left_hold_q <= '0;
      held_q      <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      ws_prev_q   <= ws_prev_d;
      left_hold_q <= left_hold_d;
      held_q      <= held_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
    end
  end

  always_comb begin
    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    ws_prev_d   = ws_prev_q;
    left_hold_d = left_hold_q;
    held_d      = held_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    locked_d    = locked_q;
    shift_app   = shift_q;
    count_app   = count_q;

    if (count_q < CW'(DATA_WIDTH)) begin
      shift_app = {shift_q[DATA_WIDTH-2:0], bit_q};
      count_app = count_q + CW'(1);
    end

    if (!enable) begin
      // Keep tracking ws so a fresh left-word start is recognised cleanly
      // after re-enable; everything else idles.
      state_d  = IDLE;
      locked_d = 1'b0;
      held_d   = 1'b0;
      if (rise_q) ws_prev_d = ws_q;
    end else if (rise_q) begin
      ws_prev_d = ws_q;
      unique case (state_q)
        IDLE: begin
          // ws 1 -> 0: this strobe carries the outgoing right LSB, the next
          // one is the MSB of a left word.
          if (!ws_q && ws_prev_q) begin
            state_d = SHIFT;
            count_d = '0;
            shift_d = '0;
          end
        end
        SHIFT: begin
          if (ws_q != ws_prev_q) begin
            // This bit is the LSB of the outgoing word (one-bit delay).
            if (count_app == CW'(DATA_WIDTH)) begin
              if (!ws_prev_q) begin
                left_hold_d = shift_app;
                held_d      = 1'b1;
                locked_d    = 1'b1;
              end else if (held_q) begin
                left_d  = left_hold_q;
                right_d = shift_app;
                valid_d = 1'b1;
                held_d  = 1'b0;
              end
            end else begin
              err_d  = 1'b1;
              held_d = 1'b0;
            end
            count_d = '0;
            shift_d = '0;
          end else begin
            count_d = count_app;
            shift_d = shift_app;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign left_data    = left_q;
  assign right_data   = right_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// -----------------------------------------------------------------------------
// tb_i2s_receiver
//
// Directed bench for i2s_receiver. A codec-side driver serialises slots with
// the I2S one-bit delay (the slot's last bit is sent after LRCLK has already
// switched), a monitor collects output pairs, and expectations come from the
// words the driver sent.
// -----------------------------------------------------------------------------
module tb_i2s_receiver;

  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          SCLK = 1'b0;
  logic          LRCLK = 1'b0;
  logic          SDIN = 1'b0;
  logic [DW-1:0] left_data, right_data;
  logic          sample_valid, frame_err, locked;

  i2s_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .enable      (enable),
    .SCLK        (SCLK),
    .LRCLK       (LRCLK),
    .SDIN        (SDIN),
    .left_data   (left_data),
    .right_data  (right_data),
    .sample_valid(sample_valid),
    .frame_err   (frame_err),
    .locked      (locked)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: sampled 1 ns after each rising edge
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  int            rise_cyc = 0;   // cycle count when the driver last raised SCLK
  int            last_lat = 0;
  int            valid_cnt = 0;
  int            err_cnt = 0;
  int            bad_both = 0;
  int            bad_hold = 0;
  logic [DW-1:0] prev_l, prev_r;
  logic [31:0]   got_q[$];
  logic [31:0]   exp_q[$];

  always @(posedge Clk) begin
    cyc++;
    #1;
    if (sample_valid) begin
      valid_cnt++;
      got_q.push_back({left_data, right_data});
      last_lat = cyc - rise_cyc;
    end
    if (frame_err) err_cnt++;
    if (sample_valid && frame_err) bad_both++;
    if (!sample_valid && Reset_n && (left_data !== prev_l || right_data !== prev_r))
      bad_hold++;
    prev_l = left_data;
    prev_r = right_data;
  end

  initial begin
    repeat (95000) @(posedge Clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Codec-side driver (called at a falling Clk edge)
  // ---------------------------------------------------------------------------
  task automatic sbit(input logic ws, input logic b, input int half);
    SCLK  = 1'b0;
    LRCLK = ws;
    SDIN  = b;
    repeat (half) @(negedge Clk);
    SCLK     = 1'b1;
    rise_cyc = cyc;
    repeat (half) @(negedge Clk);
  endtask

  // Slot of len bits for channel c carrying word w MSB first (zero padded);
  // only the first n_send bits are driven.
  task automatic send_slot(input logic c, input logic [DW-1:0] w, input int len,
                           input int n_send, input int half);
    logic b;
    logic ws;
    for (int k = 0; k < n_send; k++) begin
      b  = (k < DW) ? w[DW-1-k] : 1'b0;
      ws = (k == len - 1) ? ~c : c;
      sbit(ws, b, half);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int len, input int half);
    send_slot(1'b0, l, len, len, half);
    send_slot(1'b1, r, len, len, half);
  endtask

  task automatic clear_stats();
    valid_cnt = 0;
    err_cnt   = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic settle();
    repeat (8) @(negedge Clk);
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check(tag, got_q[i], exp_q[i]);
  endtask

  task automatic random_run(input string tag, input int frames, input int half);
    logic [DW-1:0] l, r;
    clear_stats();
    for (int f = 0; f < frames; f++) begin
      l = DW'($urandom);
      r = DW'($urandom);
      exp_q.push_back({l, r});
      send_frame(l, r, 16, half);
    end
    settle();
    compare_queues(tag);
    check({tag, "_err"}, err_cnt, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    @(negedge Clk);
    repeat (4) @(negedge Clk);
    check("rst_left",   left_data, 0);
    check("rst_right",  right_data, 0);
    check("rst_valid",  sample_valid, 0);
    check("rst_err",    frame_err, 0);
    check("rst_locked", locked, 0);
    Reset_n = 1'b1;
    enable  = 1'b1;

    // Nominal 64-bit frames. LRCLK starts low, so the first frame only
    // provides the left-word start; frames 2..4 each produce a pair.
    clear_stats();
    for (int f = 0; f < 4; f++) send_frame(16'hA5C3, 16'h1234, 32, 4);
    settle();
    for (int f = 0; f < 3; f++) exp_q.push_back(32'hA5C3_1234);
    compare_queues("nom");
    check("nom_latency", last_lat, 4);
    check("nom_err", err_cnt, 0);
    check("nom_locked", locked, 1);

    // Exact 16-bit slots: LSB coincides with the LRCLK change.
    clear_stats();
    for (int f = 0; f < 2; f++) send_frame(16'h8001, 16'h7FFE, 16, 4);
    settle();
    for (int f = 0; f < 2; f++) exp_q.push_back(32'h8001_7FFE);
    compare_queues("exact");
    check("exact_err", err_cnt, 0);

    // Short 10-bit right word after a valid left word, then recovery.
    clear_stats();
    send_slot(1'b0, 16'hA5C3, 16, 16, 4);
    send_slot(1'b1, 16'h1234, 10, 10, 4);
    settle();
    check("short_err", err_cnt, 1);
    check("short_valid", valid_cnt, 0);
    check("short_left", left_data, 16'h8001);
    check("short_right", right_data, 16'h7FFE);
    send_frame(16'h0F0F, 16'hF0F0, 16, 4);
    settle();
    exp_q.push_back(32'h0F0F_F0F0);
    compare_queues("recover");
    check("recover_err", err_cnt, 1);

    // Reset, then start in the tail of a right word.
    @(negedge Clk) Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    clear_stats();
    send_slot(1'b1, 16'h00FF, 9, 9, 4);
    settle();
    check("mid_locked0", locked, 0);
    send_slot(1'b0, 16'h1357, 32, 32, 4);
    settle();
    check("mid_locked1", locked, 1);
    check("mid_novalid", valid_cnt, 0);
    send_slot(1'b1, 16'h2468, 32, 32, 4);
    settle();
    exp_q.push_back(32'h1357_2468);
    compare_queues("mid");

    // Reset halfway through a left word.
    send_slot(1'b0, 16'hBEEF, 32, 8, 4);
    Reset_n = 1'b0;
    @(posedge Clk);
    #2;
    check("rmid_left", left_data, 0);
    check("rmid_right", right_data, 0);
    check("rmid_locked", locked, 0);
    check("rmid_valid", sample_valid, 0);
    @(negedge Clk) Reset_n = 1'b1;
    clear_stats();
    send_frame(16'h1111, 16'h2222, 16, 4);
    send_frame(16'h3333, 16'h4444, 16, 4);
    send_frame(16'h5555, 16'h6666, 16, 4);
    settle();
    exp_q.push_back(32'h3333_4444);
    exp_q.push_back(32'h5555_6666);
    compare_queues("rrec");

    // Enable dropped for 200 cycles while the stream keeps running.
    clear_stats();
    enable = 1'b0;
    send_frame(16'hDEAD, 16'hBEEF, 16, 3);
    settle();
    check("dis_valid", valid_cnt, 0);
    check("dis_err", err_cnt, 0);
    check("dis_locked", locked, 0);
    check("dis_hold", {left_data, right_data}, 32'h5555_6666);
    enable = 1'b1;
    @(negedge Clk);
    check("en_locked0", locked, 0);
    send_frame(16'hCAFE, 16'hF00D, 16, 4);
    send_frame(16'hABCD, 16'h4321, 16, 4);
    send_frame(16'h0001, 16'h8000, 16, 4);
    settle();
    exp_q.push_back(32'hABCD_4321);
    exp_q.push_back(32'h0001_8000);
    compare_queues("reen");
    check("reen_locked", locked, 1);

    // Random data at slow and at minimum SCLK.
    random_run("slow", 50, 8);
    random_run("fast", 100, 3);

    check("excl_pulses", bad_both, 0);
    check("hold_outputs", bad_hold, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
